// File: rtl/fp_compare_pipe_if.sv
// Operand/result handshake bundle for fp_compare_pipe.
// The master side issues operand sets and consumes results; the slave side is the comparator.
interface fp_compare_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a_operand;
  logic [W-1:0]     b_operand;
  logic [2:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             flag;
  logic [W-1:0]     result;
  logic             unordered;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a_operand, b_operand, op, in_tag, out_ready,
    input  in_ready, out_valid, flag, result, unordered, out_tag
  );

  modport slave (
    input  in_valid, a_operand, b_operand, op, in_tag, out_ready,
    output in_ready, out_valid, flag, result, unordered, out_tag
  );
endinterface

// File: rtl/fp_compare_pipe.sv
// Two-stage IEEE-754 comparator (GT/LT/EQ/GE/MAX/MIN) with valid/ready flow control.
// Stage 1 classifies operands and compares magnitudes; stage 2 resolves signs and registers the result.
module fp_compare_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_compare_pipe_if.slave   bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_GT  = 3'b000;
  localparam logic [2:0] OP_LT  = 3'b001;
  localparam logic [2:0] OP_EQ  = 3'b010;
  localparam logic [2:0] OP_GE  = 3'b011;
  localparam logic [2:0] OP_MAX = 3'b100;
  localparam logic [2:0] OP_MIN = 3'b101;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // A stall freezes both stages at once, so the pipe never creates bubbles.
  logic stall;
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] != '0);
  endfunction

  // Stage 1
  logic             s1_valid;
  logic [W-1:0]     s1_a, s1_b;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_a_nan, s1_b_nan, s1_a_zero, s1_b_zero, s1_mag_gt, s1_mag_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (!stall) s1_valid <= bus.in_valid;
  end

  // NOTE: datapath registers carry no reset; the valid bit alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (!stall && bus.in_valid) begin
      s1_a      <= bus.a_operand;
      s1_b      <= bus.b_operand;
      s1_op     <= bus.op;
      s1_tag    <= bus.in_tag;
      s1_a_nan  <= is_nan(bus.a_operand);
      s1_b_nan  <= is_nan(bus.b_operand);
      s1_a_zero <= (bus.a_operand[W-2:0] == '0);
      s1_b_zero <= (bus.b_operand[W-2:0] == '0);
      s1_mag_gt <= (bus.a_operand[W-2:0] >  bus.b_operand[W-2:0]);
      s1_mag_eq <= (bus.a_operand[W-2:0] == bus.b_operand[W-2:0]);
    end
  end

  // Stage 2 sign resolution
  logic         unord, both_zero, a_sign, b_sign, gt, eq, lt;
  logic         nxt_flag;
  logic [W-1:0] nxt_result;

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    unord      = s1_a_nan || s1_b_nan;
    both_zero  = s1_a_zero && s1_b_zero;
    a_sign     = s1_a[W-1];
    b_sign     = s1_b[W-1];
    nxt_flag   = 1'b0;
    nxt_result = '0;
    gt         = 1'b0;
    eq         = both_zero || ((a_sign == b_sign) && s1_mag_eq);
    if (both_zero)             gt = 1'b0;
    else if (a_sign != b_sign) gt = !a_sign;
    else if (a_sign)           gt = !s1_mag_gt && !s1_mag_eq;
    else                       gt = s1_mag_gt;
    lt = !eq && !gt;

    case (s1_op)
      OP_GT: nxt_flag = !unord && gt;
      OP_LT: nxt_flag = !unord && lt;
      OP_EQ: nxt_flag = !unord && eq;
      OP_GE: nxt_flag = !unord && (gt || eq);
      OP_MAX, OP_MIN: begin
        if (s1_a_nan && s1_b_nan) nxt_result = QNAN;
        else if (s1_a_nan)        nxt_result = s1_b;
        else if (s1_b_nan)        nxt_result = s1_a;
        else if (s1_op == OP_MAX) nxt_result = (gt || eq) ? s1_a : s1_b;
        else                      nxt_result = (lt || eq) ? s1_a : s1_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.flag      <= 1'b0;
      bus.result    <= '0;
      bus.unordered <= 1'b0;
      bus.out_tag   <= '0;
    end else if (!stall) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.flag      <= nxt_flag;
        bus.result    <= nxt_result;
        bus.unordered <= unord;
        bus.out_tag   <= s1_tag;
      end
    end
  end
endmodule
